// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encoding and constants for the unified-memory arbiter.
package mem_arbiter_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int XLEN = 32;
  localparam logic [3:0] BE_WORD = 4'hF;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_D = 3'd1,
    ST_WAIT_D  = 3'd2,
    ST_ISSUE_I = 3'd3,
    ST_WAIT_I  = 3'd4
  } state_t;
endpackage

// File: rtl/mem_arbiter_arb_prio2.sv
// arb_prio2: combinational fixed-priority 2-way grant (data over fetch); a requester whose
// ready pulse is high this cycle is masked so one request is never granted twice.
module arb_prio2
  import mem_arbiter_pkg::*;
(
  input  logic i_req_d,
  input  logic i_rdy_d,
  input  logic i_req_i,
  input  logic i_rdy_i,
  input  logic i_kill_i,
  output logic o_gnt_d,
  output logic o_gnt_i
);
  assign o_gnt_d = i_req_d & ~i_rdy_d;
  assign o_gnt_i = ~o_gnt_d & i_req_i & ~i_rdy_i & ~i_kill_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between IF fetch and MEM load/store, one transaction at a time.
// Define MEMARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles with a mem_err pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_SIZE,
  parameter int DATA_W  = XLEN,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEMARB_TIMEOUT_EN
  output logic              mem_err,
`endif
  output logic              stall_if,
  output logic              stall_mem
);
  state_t r_state, w_next;
  logic r_mem_req, r_mem_we, r_if_ready, r_dm_ready, r_kill;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_dm_rdata, w_rd;
  logic [3:0] r_mem_be;
  logic w_gnt_d, w_gnt_i, w_go, w_wait, w_wait_i, w_done, w_tmo, w_fire_i;

  arb_prio2 u_prio (
    .i_req_d (dm_req),
    .i_rdy_d (r_dm_ready),
    .i_req_i (if_req),
    .i_rdy_i (r_if_ready),
    .i_kill_i(if_kill),
    .o_gnt_d (w_gnt_d),
    .o_gnt_i (w_gnt_i)
  );

  assign w_go     = (r_state == ST_IDLE) & (w_gnt_d | w_gnt_i);
  assign w_wait_i = r_state == ST_WAIT_I;
  assign w_wait   = w_wait_i | (r_state == ST_WAIT_D);
  assign w_done   = w_wait & (mem_ready | w_tmo);
  // a kill seen earlier or in the response cycle swallows the fetch result
  assign w_fire_i = w_done & w_wait_i & ~r_kill & ~if_kill;
  assign w_rd     = w_tmo ? '0 : mem_rdata;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic r_err;
  assign w_tmo   = w_wait & ~mem_ready & (r_cnt == CW'(TIMEOUT - 1));
  assign mem_err = r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CW'(w_wait);
      r_err <= w_tmo;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:              w_next = w_gnt_d ? ST_ISSUE_D : (w_gnt_i ? ST_ISSUE_I : ST_IDLE);
      ST_ISSUE_D:           w_next = ST_WAIT_D;
      ST_ISSUE_I:           w_next = ST_WAIT_I;
      ST_WAIT_D, ST_WAIT_I: w_next = w_done ? ST_IDLE : r_state;
      default:              w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_kill      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mem_req  <= w_go;
      r_if_ready <= w_fire_i;
      r_dm_ready <= w_done & ~w_wait_i;
      r_kill     <= w_go ? 1'b0 : (r_kill | (if_kill & ((r_state == ST_ISSUE_I) | w_wait_i)));
      if (w_go) begin
        r_mem_addr <= w_gnt_d ? dm_addr : if_addr;
        r_mem_we   <= w_gnt_d & dm_we;
        r_mem_be   <= w_gnt_d ? dm_be : BE_WORD;
        if (w_gnt_d) r_mem_wdata <= dm_wdata;
      end
      if (w_fire_i) r_if_rdata <= w_rd;
      if (w_done & ~w_wait_i & (~r_mem_we | w_tmo)) r_dm_rdata <= w_rd;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign stall_if  = if_req & ~r_if_ready;
  assign stall_mem = dm_req & ~r_dm_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (reset table, directed corner cases,
// randomized traffic against a transaction-level reference model).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_req = 1'b0, if_kill = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0] dm_be = '0;
  logic if_ready, dm_ready, mem_req, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
`ifdef MEMARB_TIMEOUT_EN
  logic mem_err;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
`ifdef MEMARB_TIMEOUT_EN
    .mem_err(mem_err),
`endif
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h4) ? 32'h0010_0093 : ((a * 32'h9E37_79B9) ^ 32'h5A5A_1234);
  endfunction

  // memory model: answers each mem_req after lat cycles unless hang is set
  bit mem_auto = 1, noise = 0, hang = 0, pend = 0, resp_now = 0, resp_prev = 0, t_we = 0;
  int lat = 1, cnt = 0;
  logic [31:0] t_addr = '0;

  task automatic step();
    @(posedge clk);
    #1;
    resp_prev = resp_now;
    resp_now = 1'b0;
    if (mem_auto) begin
      mem_ready = 1'b0;
      if (mem_req) begin
        pend = 1'b1;
        cnt = lat;
        t_addr = mem_addr;
        t_we = mem_we;
      end else if (pend && cnt > 0) begin
        cnt--;
        if (cnt == 0 && !hang) begin
          mem_ready = 1'b1;
          mem_rdata = t_we ? $urandom : mem_val(t_addr);
          pend = 1'b0;
          resp_now = 1'b1;
        end
      end else if (!pend && noise) begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  endtask

  typedef struct {
    logic ir, dr, k, e_si, e_sm;
  } vec_t;
  vec_t vt[4];

  int got, got_i, d_cyc, i_cyc;
  logic [31:0] iss[$];
  int iss_c[$];
  logic [31:0] exp_dm, exp_if, d_a, d_wd, i_a;
  logic [3:0] d_b;
  bit d_w, d_act, d_rs, i_act, i_rs, busy, own_d, prev_dw, prev_iw;
  int d_age, i_age, max_age, n_d, n_i;

  initial begin
    // reset state and combinational stalls while reset is held
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step();
      if_req = vt[i].ir;
      dm_req = vt[i].dr;
      if_kill = vt[i].k;
      #1;
      chk1("tbl_stall_if", stall_if, vt[i].e_si);
      chk1("tbl_stall_mem", stall_mem, vt[i].e_sm);
      chk1("tbl_mem_req", mem_req, 1'b0);
      chk1("tbl_readies", if_ready | dm_ready, 1'b0);
    end
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    step();
    if_req = 0; dm_req = 0; if_kill = 0;
    reset = 1'b0;
    step();

    // lone fetch, 1-cycle memory
    lat = 1; if_req = 1; if_addr = 32'h4;
    #1 chk1("lf_stall_c0", stall_if, 1'b1);
    step();
    chk1("lf_mem_req", mem_req, 1'b1);
    chk("lf_mem_addr", mem_addr, 32'h4);
    chk1("lf_mem_we", mem_we, 1'b0);
    chk("lf_mem_be", 32'(mem_be), 32'hF);
    chk1("lf_stall_c1", stall_if, 1'b1);
    step();
    chk1("lf_req_once", mem_req, 1'b0);
    chk1("lf_rdy_c2", if_ready, 1'b0);
    chk1("lf_stall_c2", stall_if, 1'b1);
    step();
    chk1("lf_if_ready", if_ready, 1'b1);
    chk("lf_if_rdata", if_rdata, 32'h0010_0093);
    chk1("lf_stall_c3", stall_if, 1'b0);
    step();
    chk1("lf_rdy_pulse", if_ready, 1'b0);
    chk1("lf_no_regrant", mem_req, 1'b0);
    if_req = 0;
    step();

    // collision: data (load, latency 2) wins over fetch
    lat = 2; if_req = 1; if_addr = 32'h40;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_be = 4'hF;
    d_cyc = -1; i_cyc = -1; got = 0; got_i = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (d_cyc > 0 && c == d_cyc + 1) dm_req = 0;
      if (i_cyc > 0 && c == i_cyc + 1) if_req = 0;
      if (mem_req) begin iss.push_back(mem_addr); iss_c.push_back(c); end
      if (dm_ready) begin d_cyc = c; got = int'(dm_rdata); end
      if (if_ready) begin i_cyc = c; got_i = int'(if_rdata); end
    end
    chk("col_n_issue", iss.size(), 2);
    if (iss.size() == 2) begin
      chk("col_first_addr", iss[0], 32'h100);
      chk("col_second_addr", iss[1], 32'h40);
      chk("col_d_issue_cyc", iss_c[0], 1);
      chk("col_fetch_after_dm", iss_c[1], d_cyc + 1);
      chk("col_i_ready_cyc", i_cyc, iss_c[1] + 3);
    end
    chk("col_d_ready_cyc", d_cyc, 4);
    chk("col_dm_rdata", got, mem_val(32'h100));
    chk("col_if_rdata", got_i, mem_val(32'h40));

    // store
    lat = 1; dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
    step();
    chk1("st_mem_req", mem_req, 1'b1);
    chk1("st_mem_we", mem_we, 1'b1);
    chk("st_mem_addr", mem_addr, 32'h200);
    chk("st_mem_be", 32'(mem_be), 32'h3);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    step();
    chk1("st_dm_ready", dm_ready, 1'b1);
    chk("st_dm_rdata", dm_rdata, mem_val(32'h100));
    step();
    chk1("st_no_regrant", mem_req, 1'b0);
    dm_req = 0; dm_we = 0;

    // kill during WAIT_I, response 2 cycles later
    lat = 3; if_req = 1; if_addr = 32'h80;
    step();
    chk1("kl_mem_req", mem_req, 1'b1);
    lat = 1;
    step();
    if_kill = 1;
    step();
    if_kill = 0; if_addr = 32'h300;
    step();
    chk1("kl_resp_now", mem_ready, 1'b1);
    step();
    chk1("kl_no_ready", if_ready, 1'b0);
    chk("kl_rdata_kept", if_rdata, mem_val(32'h40));
    step();
    chk1("kl_regrant", mem_req, 1'b1);
    chk("kl_regrant_addr", mem_addr, 32'h300);
    step();
    step();
    chk1("kl_next_ready", if_ready, 1'b1);
    chk("kl_next_rdata", if_rdata, mem_val(32'h300));
    step();
    if_addr = 32'h500;
    step();
    step();
    if_kill = 1;
    step();
    chk1("kl_same_cyc", if_ready, 1'b0);
    chk("kl_same_rdata", if_rdata, mem_val(32'h300));
    if_kill = 0; if_req = 0;
    step();
    chk1("kl_idle", mem_req, 1'b0);

    // reset mid-WAIT_D, then a stale mem_ready
    mem_auto = 0; mem_ready = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h104; dm_be = 4'hF;
    step();
    chk1("rw_issue", mem_req, 1'b1);
    step();
    reset = 1; dm_req = 0;
    #1;
    chk("rw_outs", {mem_req, mem_we, if_ready, dm_ready, mem_be}, 0);
    chk("rw_addr", mem_addr, 0);
    chk("rw_dm_rdata", dm_rdata, 0);
    chk("rw_if_rdata", if_rdata, 0);
    step();
    reset = 0; mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_ready = 0;
    chk1("rw_stale_rdy", dm_ready, 1'b0);
    chk1("rw_stale_req", mem_req, 1'b0);
    step();
    chk1("rw_stale_rdy2", dm_ready, 1'b0);
    chk("rw_stale_rdata", dm_rdata, 0);
    mem_auto = 1; pend = 0; lat = 1;
    dm_req = 1; dm_addr = 32'h108;
    got = -1;
    for (int c = 1; c <= 10 && got < 0; c++) begin
      step();
      if (dm_ready) got = c;
    end
    chk("rw_latency", got, 3);
    chk("rw_dm_rdata2", dm_rdata, mem_val(32'h108));
    step();
    dm_req = 0;
    exp_dm = mem_val(32'h108);
    exp_if = 32'h0;

`ifdef MEMARB_TIMEOUT_EN
    hang = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h10;
    got = -1; got_i = -1;
    for (int c = 1; c <= 20 && got < 0; c++) begin
      step();
      if (dm_ready) got = c;
      if (mem_err && got_i < 0) got_i = c;
    end
    chk("to_ready_cyc", got, 10);
    chk("to_err_cyc", got_i, 10);
    chk("to_rdata", dm_rdata, 0);
    step();
    chk1("to_err_pulse", mem_err, 1'b0);
    dm_req = 0; hang = 0; pend = 0;
    exp_dm = 32'h0;
`endif
    step();
    step();

    // randomized traffic against the transaction-level model
    noise = 1;
    d_act = 0; d_rs = 0; i_act = 0; i_rs = 0; busy = 0; own_d = 0; prev_dw = 0; prev_iw = 0;
    d_age = 0; i_age = 0; max_age = 0; n_d = 0; n_i = 0;
    d_a = '0; d_wd = '0; d_b = '0; d_w = 0; i_a = '0;
    for (int c = 0; c < 3000; c++) begin
      lat = $urandom_range(1, 4);
      step();
      chk1("rnd_dm_ready", dm_ready, resp_prev & own_d);
      chk1("rnd_if_ready", if_ready, resp_prev & ~own_d);
      if (resp_prev) begin
        busy = 0;
        if (own_d && !d_w) exp_dm = mem_val(d_a);
        if (!own_d) exp_if = mem_val(i_a);
      end
      chk("rnd_dm_rdata", dm_rdata, exp_dm);
      chk("rnd_if_rdata", if_rdata, exp_if);
      if (mem_req) begin
        chk1("rnd_one_outstanding", busy, 1'b0);
        chk1("rnd_grant_had_req", prev_dw | prev_iw, 1'b1);
        busy = 1;
        own_d = prev_dw;
        chk("rnd_mem_addr", mem_addr, own_d ? d_a : i_a);
        chk1("rnd_mem_we", mem_we, own_d & d_w);
        chk("rnd_mem_be", 32'(mem_be), own_d ? 32'(d_b) : 32'hF);
        if (own_d && d_w) chk("rnd_mem_wdata", mem_wdata, d_wd);
      end
      if (d_rs) begin d_rs = 0; d_act = 0; dm_req = 0; n_d++; d_age = 0; end
      if (dm_ready) d_rs = 1;
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_a = $urandom; d_w = 1'($urandom_range(0, 1)); d_wd = $urandom; d_b = 4'($urandom);
        dm_req = 1; dm_we = d_w; dm_addr = d_a; dm_wdata = d_wd; dm_be = d_b;
      end
      if (d_act) begin d_age++; if (d_age > max_age) max_age = d_age; end
      if (i_rs) begin i_rs = 0; i_act = 0; if_req = 0; n_i++; i_age = 0; end
      if (if_ready) i_rs = 1;
      if (!i_act && $urandom_range(0, 1) == 0) begin
        i_act = 1; i_a = $urandom; if_req = 1; if_addr = i_a;
      end
      if (i_act) begin i_age++; if (i_age > max_age) max_age = i_age; end
      prev_dw = d_act & ~d_rs;
      prev_iw = i_act & ~i_rs;
      #1;
      chk1("rnd_stall_if", stall_if, prev_iw);
      chk1("rnd_stall_mem", stall_mem, prev_dw);
    end
    chk1("rnd_max_wait", max_age <= 24, 1'b1);
    chk1("rnd_dm_progress", n_d > 100, 1'b1);
    chk1("rnd_if_progress", n_i > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Fixed priority: data over fetch. One transaction outstanding at a time.
- Issues `mem_req` to the memory and tracks variable latency until `mem_ready`.
- Returns read data to the winning requester and drives the stall signals that freeze the PC and IF/ID register (fetch) or the whole pipe (data).

Parameters:
- ADDR_W, 32, address width (equals `ADDR_SIZE`)
- DATA_W, 32, data width (equals `XLEN`)
- TIMEOUT, 64, maximum WAIT cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address (pcF)
- if_kill  in  1  fetch cancelled by a taken branch/jump (pcsrc)
- if_ready  out  1  one-cycle pulse: fetch data valid
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = store
- dm_addr  in  ADDR_W  data address (aluoutM)
- dm_wdata  in  DATA_W  store data
- dm_be  in  4  byte enables (sb/sh/sw)
- dm_ready  out  1  one-cycle pulse: data access done
- dm_rdata  out  DATA_W  load data
- mem_req  out  1  one-cycle request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_ready  in  1  memory response/ack; at least 1 cycle after mem_req
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- stall_if  out  1  freeze PC and IF/ID
- stall_mem  out  1  freeze the whole pipeline

Behaviour:
- Reset values:
  - State = IDLE.
  - mem_req, mem_we, if_ready, dm_ready = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0; mem_be = 0.
- FSM states: IDLE, ISSUE_D, WAIT_D, ISSUE_I, WAIT_I.
- IDLE:
  - If dm_req and not dm_ready, go to ISSUE_D.
  - Else if if_req, not if_ready and not if_kill, go to ISSUE_I.
  - Requests whose ready pulse is high this cycle are ignored (no double grant).
- Entering ISSUE_x:
  - Register mem_addr/mem_we/mem_wdata/mem_be from the winner.
  - mem_req = 1 for exactly the ISSUE cycle; fetch uses we = 0, be = 4'hF.
  - ISSUE_x always goes to WAIT_x.
- WAIT_x on mem_ready:
  - Capture mem_rdata into x_rdata, pulse x_ready the next cycle, go to IDLE.
  - mem_ready in any other state is ignored.
- Kill during a fetch:
  - if_kill seen in ISSUE_I or WAIT_I sets a kill flag.
  - The response is still consumed, but if_ready is not pulsed and if_rdata is unchanged.
  - if_kill in the same cycle as mem_ready also suppresses the pulse.
- Minimum latency: request-to-ready = 3 cycles with 1-cycle memory (grant edge, ISSUE, WAIT with mem_ready, ready pulse).
- Stalls (combinational):
  - stall_if = if_req & ~if_ready.
  - stall_mem = dm_req & ~dm_ready.
  - stall_mem takes precedence; the hazard unit ORs stall_if into PCNOTCHANGE.
- Simultaneous if_req and dm_req in IDLE: data wins; fetch waits, so the older instruction completes first.
- Reset mid-transaction: return to IDLE immediately, with no ready pulse. A stale mem_ready arriving later is ignored.
- Stores: dm_rdata is unchanged; dm_ready still pulses.

Optional Feature:
- Macro: MEMARB_TIMEOUT_EN.
- When defined:
  - A WAIT-cycle counter runs in WAIT_x.
  - At TIMEOUT cycles, abort: pulse x_ready with x_rdata = 0, pulse the extra output port `mem_err` (1 bit, reset 0) for one cycle, and return to IDLE.
  - The counter clears on every state entry.
- When undefined: no counter and no mem_err port; WAIT lasts indefinitely.

Decomposition:
- Shared package / xgriscv_defines.v:
  - FSM state encoding (3-bit localparams ST_IDLE..ST_WAIT_I).
  - `ADDR_SIZE`/`XLEN` reuse.
  - BE_WORD = 4'hF.
- Sub-module arb_prio2: a combinational fixed-priority 2-way grant (data > fetch, with ready masking).
- FSM and registers stay in mem_arbiter.

Test Plan:
- Lone fetch: if_req = 1, if_addr = 0x0000_0004, memory latency 1, mem_rdata = 0x0010_0093 → mem_req for 1 cycle with addr 0x4, we = 0; if_ready pulses 3 cycles after the request with if_rdata = 0x0010_0093; stall_if high for exactly the cycles in between.
- Collision: if_req and dm_req (load, addr 0x100, latency 2) rise together → the data transaction is issued first and dm_ready precedes any fetch mem_req; the fetch is then issued with if_addr.
- Store: dm_we = 1, addr 0x200, wdata 0xDEAD_BEEF, be 4'b0011 → mem_we = 1, mem_be = 4'b0011, mem_wdata = 0xDEAD_BEEF; dm_ready pulses; dm_rdata unchanged.
- Kill: fetch in WAIT_I, if_kill pulsed, mem_ready arrives 2 cycles later → no if_ready and if_rdata unchanged; the next fetch is granted normally.
- Reset mid-WAIT_D, then mem_ready arrives → all outputs are 0, no dm_ready, state IDLE; a following request works with normal latency.
- (MEMARB_TIMEOUT_EN, TIMEOUT = 8) memory never returns mem_ready → dm_ready with dm_rdata = 0 and a mem_err pulse 8 cycles after WAIT_D entry.
